switch_input_port: RTL and testbench



---
 rtl/switch_input_port.sv | 131 +++++++++++++
 tb/tb_switch_input_port.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/switch_input_port.sv
// Switch input port: synchronizes switches and confirm button, debounces the button,
// and latches a switch snapshot per confirmed press for the CPU to read.
module switch_input_port #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DB_CNT_W        = 20
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        ior,
   input  logic        switchctrl,
   input  logic [1:0]  ioaddr,
   input  logic [15:0] switches,
   input  logic        confirm_button,
   output logic [15:0] ioread_data,
   output logic        data_valid,
   output logic        overrun
);

   typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

   localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                btn_m_q, btn_s_q;
   logic [15:0]         sw_m_q, sw_s_q;
   logic                btn_db_q, btn_db_d;
   logic                btn_db_dly_q;
   logic [DB_CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]          prime_q, prime_d;
   logic                armed_q, armed_d;
   state_t              state_q, state_d;
   logic [15:0]         hold_q, hold_d;
   logic                overrun_q, overrun_d;
   logic                press, rd_data, rd_stat;

   always_comb begin
      btn_db_d = btn_db_q;
      cnt_d    = cnt_q;
      if (btn_s_q == btn_db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         btn_db_d = btn_s_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + DB_CNT_W'(1);
      end
   end

   // btn_s only reflects the real button two edges after reset; a press is accepted
   // only once the button has been seen released, so a button held through reset is ignored.
   always_comb begin
      prime_d = {prime_q[0], 1'b1};
      armed_d = armed_q | (prime_q[1] & ~btn_s_q);
   end

   assign press   = btn_db_q & ~btn_db_dly_q & armed_q;
   assign rd_data = ior & switchctrl & (ioaddr == 2'b00);
   assign rd_stat = ior & switchctrl & (ioaddr == 2'b10);

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      overrun_d = overrun_q;
      if (rd_stat) begin
         overrun_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (press) begin
               hold_d  = sw_s_q;
               state_d = FULL;
            end
         end
         FULL: begin
            if (press) begin
               hold_d = sw_s_q;
               if (!rd_data) begin
                  overrun_d = 1'b1;
               end
            end else if (rd_data) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst) begin
         btn_m_q      <= 1'b0;
         btn_s_q      <= 1'b0;
         sw_m_q       <= '0;
         sw_s_q       <= '0;
         btn_db_q     <= 1'b0;
         btn_db_dly_q <= 1'b0;
         cnt_q        <= '0;
         prime_q      <= '0;
         armed_q      <= 1'b0;
         state_q      <= IDLE;
         hold_q       <= '0;
         overrun_q    <= 1'b0;
      end else begin
         btn_m_q      <= confirm_button;
         btn_s_q      <= btn_m_q;
         sw_m_q       <= switches;
         sw_s_q       <= sw_m_q;
         btn_db_q     <= btn_db_d;
         btn_db_dly_q <= btn_db_q;
         cnt_q        <= cnt_d;
         prime_q      <= prime_d;
         armed_q      <= armed_d;
         state_q      <= state_d;
         hold_q       <= hold_d;
         overrun_q    <= overrun_d;
      end
   end

   assign data_valid = (state_q == FULL);
   assign overrun    = overrun_q;

   always_comb begin
      ioread_data = 16'h0000;
      if (ior & switchctrl) begin
         case (ioaddr)
            2'b00:   ioread_data = hold_q;
            2'b10:   ioread_data = {14'b0, overrun_q, data_valid};
            default: ioread_data = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port with DEBOUNCE_CYCLES = 4: a per-cycle vector
// table for reset and a clean press, then hand sequences for the multi-cycle corners.
module tb_switch_input_port;

   logic        clock = 1'b0;
   logic        rst;
   logic        ior;
   logic        switchctrl;
   logic [1:0]  ioaddr;
   logic [15:0] switches;
   logic        confirm_button;
   logic [15:0] ioread_data;
   logic        data_valid;
   logic        overrun;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   switch_input_port #(
      .DEBOUNCE_CYCLES(4),
      .DB_CNT_W       (3)
   ) dut (
      .clock         (clock),
      .rst           (rst),
      .ior           (ior),
      .switchctrl    (switchctrl),
      .ioaddr        (ioaddr),
      .switches      (switches),
      .confirm_button(confirm_button),
      .ioread_data   (ioread_data),
      .data_valid    (data_valid),
      .overrun       (overrun)
   );

   // rd: 0 = no access, 1 = data read, 2 = status read
   typedef struct {
      logic        rst_n;
      int          rd;
      logic [15:0] sw;
      logic        btn;
      logic        chk;
      logic [15:0] exp_data;
      logic        exp_dv;
      logic        exp_ov;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, int rd, logic [15:0] sw, logic b, logic c,
                               logic [15:0] ed, logic edv, logic eov);
      vec_t v;
      v.rst_n = r; v.rd = rd; v.sw = sw; v.btn = b; v.chk = c;
      v.exp_data = ed; v.exp_dv = edv; v.exp_ov = eov;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic set_rd(input int kind);
      ior        = (kind != 0);
      switchctrl = (kind != 0);
      ioaddr     = (kind == 2) ? 2'b10 : 2'b00;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic read_check(input int kind, input string name, input logic [15:0] exp);
      set_rd(kind);
      #1;
      check(name, ioread_data, exp);
      step();
      set_rd(0);
   endtask

   task automatic press_cycle(input logic [15:0] sw);
      switches       = sw;
      confirm_button = 1'b1;
      repeat (8) step();
      confirm_button = 1'b0;
      repeat (8) step();
   endtask

   initial begin
      rst = 1'b0; ior = 1'b0; switchctrl = 1'b0; ioaddr = 2'b00;
      switches = 16'hFFFF; confirm_button = 1'b1;

      // reset with button held, held-button ignored, release, then clean press and read
      tbl.push_back(mk(1'b0, 0, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 0, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 2, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1'b1, 0, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 2, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));
      for (int i = 0; i < 7; i++)
         tbl.push_back(mk(1'b1, 0, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0));
      for (int i = 0; i < 7; i++)
         tbl.push_back(mk(1'b1, 0, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 1, 16'h1234, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0));
      tbl.push_back(mk(1'b1, 2, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 0, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0));

      foreach (tbl[i]) begin
         rst            = tbl[i].rst_n;
         switches       = tbl[i].sw;
         confirm_button = tbl[i].btn;
         set_rd(tbl[i].rd);
         #1;
         if (tbl[i].chk) begin
            check($sformatf("vec%0d data", i), ioread_data, tbl[i].exp_data);
            check($sformatf("vec%0d valid", i), {15'b0, data_valid}, {15'b0, tbl[i].exp_dv});
            check($sformatf("vec%0d overrun", i), {15'b0, overrun}, {15'b0, tbl[i].exp_ov});
         end
         step();
      end
      set_rd(0);
      confirm_button = 1'b0;
      repeat (8) step();

      // glitch of 3 cycles is discarded
      confirm_button = 1'b1;
      repeat (3) step();
      confirm_button = 1'b0;
      repeat (6) step();
      check("glitch valid", {15'b0, data_valid}, 16'h0000);
      check("glitch cnt", {13'b0, dut.cnt_q}, 16'h0000);
      read_check(2, "glitch status", 16'h0000);

      // overrun: two presses without a read, newest value wins
      press_cycle(16'h00AA);
      check("ovr first valid", {15'b0, data_valid}, 16'h0001);
      check("ovr first overrun", {15'b0, overrun}, 16'h0000);
      press_cycle(16'h0055);
      check("ovr second overrun", {15'b0, overrun}, 16'h0001);
      ior = 1'b1; switchctrl = 1'b0; ioaddr = 2'b00; #1;
      check("unselected read", ioread_data, 16'h0000);
      ior = 1'b1; switchctrl = 1'b1; ioaddr = 2'b01; #1;
      check("addr01 read", ioread_data, 16'h0000);
      ioaddr = 2'b11; #1;
      check("addr11 read", ioread_data, 16'h0000);
      step();
      set_rd(0);
      read_check(2, "ovr status", 16'h0003);
      read_check(1, "ovr data", 16'h0055);
      read_check(2, "ovr status after", 16'h0000);

      // read coincides with the press event while FULL
      press_cycle(16'h0011);
      check("simul pre valid", {15'b0, data_valid}, 16'h0001);
      switches       = 16'h0022;
      confirm_button = 1'b1;
      repeat (6) step();
      read_check(1, "simul read old", 16'h0011);
      check("simul valid kept", {15'b0, data_valid}, 16'h0001);
      read_check(2, "simul status", 16'h0001);
      read_check(1, "simul data new", 16'h0022);
      check("simul valid after", {15'b0, data_valid}, 16'h0000);
      confirm_button = 1'b0;
      repeat (8) step();

      // reset in the middle of debounce; a fresh release+press is needed afterwards
      switches       = 16'h0077;
      confirm_button = 1'b1;
      repeat (4) step();
      check("mid cnt", {13'b0, dut.cnt_q}, 16'h0002);
      rst = 1'b0;
      step();
      rst = 1'b1;
      repeat (10) step();
      check("mid valid", {15'b0, data_valid}, 16'h0000);
      read_check(1, "mid data", 16'h0000);
      read_check(2, "mid status", 16'h0000);
      confirm_button = 1'b0;
      repeat (8) step();
      press_cycle(16'h0099);
      check("mid repress valid", {15'b0, data_valid}, 16'h0001);
      read_check(1, "mid repress data", 16'h0099);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
